// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int MD_WIDTH = 32;
  localparam int CNT_W    = $clog2(MD_WIDTH);

  // Values equal instruction funct3
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_e;

  // rs1 is interpreted as signed for these ops
  function automatic logic a_is_signed(muldiv_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  // rs2 is interpreted as signed for these ops
  function automatic logic b_is_signed(muldiv_op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and the muldiv unit.
interface muldiv_if #(parameter int WIDTH = 32);
  import muldiv_pkg::*;

  logic             start;
  logic             kill;
  muldiv_op_e       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (output start, kill, op, a, b, input busy, done, result);
  modport slave  (input start, kill, op, a, b, output busy, done, result);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: one shift-add or restoring-divide step per
// cycle over a 2*WIDTH accumulator, fixed WIDTH+2 cycle latency.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e             state_q, state_d;
  muldiv_op_e         op_q, op_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;    // multiplicand (mul) or divisor (div) magnitude
  logic [2*WIDTH-1:0] acc_q, acc_d;      // {hi, lo}: product, or {remainder, quotient}
  logic               neg_q, neg_d;      // negate the selected result at FIN
  logic               div0_q, div0_d;
  logic               ovf_q, ovf_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic               sa, sb;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum, div_sh_hi, div_trial;
  logic               div_nb;
  logic [2*WIDTH-1:0] mul_nxt, div_nxt, prod;
  logic [WIDTH-1:0]   quo_s, rem_s, fin_res;

  // Operand magnitudes at load and one iteration step of each datapath
  always_comb begin
    sa    = a_is_signed(bus.op) & bus.a[WIDTH-1];
    sb    = b_is_signed(bus.op) & bus.b[WIDTH-1];
    abs_a = sa ? ('0 - bus.a) : bus.a;
    abs_b = sb ? ('0 - bus.b) : bus.b;

    // Shift-add: multiplier bit at acc[0], carry shifts into the top
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_nxt = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring: shift {rem,quo} left, trial-subtract, quotient bit = no borrow.
    // The shifted remainder is below 2*divisor, so bit WIDTH of the
    // difference is a clean borrow flag.
    div_sh_hi = acc_q[2*WIDTH-1:WIDTH-1];
    div_trial = div_sh_hi - {1'b0, opnd_q};
    div_nb    = ~div_trial[WIDTH];
    div_nxt   = {div_nb ? div_trial[WIDTH-1:0] : div_sh_hi[WIDTH-1:0],
                 acc_q[WIDTH-2:0], div_nb};
  end

  // Sign correction and special-case overrides for the final result
  always_comb begin
    prod  = neg_q ? ('0 - acc_q) : acc_q;
    quo_s = neg_q ? ('0 - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    rem_s = neg_q ? ('0 - acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
    unique case (op_q)
      OP_MUL:                      fin_res = prod[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fin_res = prod[2*WIDTH-1:WIDTH];
      OP_DIV:  fin_res = div0_q ? '1 : (ovf_q ? MIN_NEG : quo_s);
      OP_DIVU: fin_res = div0_q ? '1 : quo_s;
      // With b==0 the remainder register holds |a|; sign-of-a restores a
      OP_REM:  fin_res = ovf_q ? '0 : rem_s;
      OP_REMU: fin_res = rem_s;
      default: fin_res = '0;
    endcase
  end

  // Next-state for FSM, datapath registers and registered outputs
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    div0_d   = div0_q;
    ovf_d    = ovf_q;
    result_d = result_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: if (bus.start) begin
        op_d   = bus.op;
        cnt_d  = CW'(WIDTH-1);
        div0_d = (bus.b == '0);
        ovf_d  = (bus.a == MIN_NEG) && (bus.b == '1);
        if (bus.op[2]) begin
          opnd_d = abs_b;
          acc_d  = {{WIDTH{1'b0}}, abs_a};
          neg_d  = bus.op[1] ? sa : (sa ^ sb);
        end else begin
          opnd_d = abs_a;
          acc_d  = {{WIDTH{1'b0}}, abs_b};
          neg_d  = sa ^ sb;
        end
        state_d = CALC;
      end
      CALC: begin
        acc_d = op_q[2] ? div_nxt : mul_nxt;
        if (cnt_q == '0) state_d = FIN;
        else             cnt_d   = cnt_q - 1'b1;
      end
      FIN: begin
        result_d = fin_res;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Flush abandons the in-flight op; result keeps its old value
    if (bus.kill && state_q != IDLE) begin
      state_d  = IDLE;
      result_d = result_q;
      done_d   = 1'b0;
    end
    busy_d = (state_d != IDLE);
  end

  // State registers with async active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= OP_MUL;
      cnt_q    <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      div0_q   <= div0_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: driver pushes model results with due
// cycle, monitor pops and compares on every done pulse.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  typedef struct {
    logic [31:0] res;
    int          due;
    string       tag;
  } exp_t;

  logic gclk, grst_n;
  int   checks = 0, errors = 0, cyc = 0;
  exp_t sb[$];
  logic [31:0] last_res = '0;

  muldiv_if #(.WIDTH(32)) bus();

  muldiv_unit #(.WIDTH(32)) dut (.clk(gclk), .rst_n(grst_n), .bus(bus));

  initial begin
    gclk = 1'b0;
    forever #5 gclk = ~gclk;
  end

  always @(posedge gclk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "timeout");
  end

  // Architectural reference using 64-bit arithmetic
  function automatic logic [31:0] ref_model(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = $signed(a); sb = $signed(b);
    ua = {32'b0, a}; ub = {32'b0, b};
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Monitor: every done pops one expectation; missing dones time out
  always @(negedge gclk) begin
    if (grst_n) begin
      if (bus.done) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done got=%h cyc=%0d", bus.result, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (bus.result !== e.res || cyc != e.due || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL sb_%s got=%h cyc=%0d busy=%b want=%h cyc=%0d busy=0",
                     e.tag, bus.result, cyc, bus.busy, e.res, e.due);
          end
        end
      end else if (sb.size() > 0 && cyc > sb[0].due) begin
        exp_t e;
        e = sb.pop_front();
        checks++; errors++;
        $display("FAIL missing_done_%s got=none want=%h cyc=%0d", e.tag, e.res, e.due);
      end
    end
  end

  task automatic issue(input muldiv_op_e op, input logic [31:0] a, input logic [31:0] b,
                       input bit exp_on);
    exp_t e;
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    if (exp_on) begin
      e.res = ref_model(op, a, b);
      e.due = cyc + 34;
      e.tag = op.name();
      sb.push_back(e);
      last_res = e.res;
    end
    @(negedge gclk);
    bus.start = 1'b0;
    bus.a = $urandom; bus.b = $urandom;   // must not be resampled
  endtask

  // Counts busy cycles; returns positioned on the cycle busy drops
  task automatic run_done(output int n);
    n = 0;
    while (bus.busy && n < 60) begin
      n++;
      @(negedge gclk);
    end
  endtask

  task automatic op_dir(input muldiv_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] want, input string name);
    int n;
    issue(op, a, b, 1'b1);
    run_done(n);
    chk({name, "_lat"}, n, 33);
    chk(name, bus.result, want);
    @(negedge gclk);
  endtask

  initial begin
    int n;
    grst_n = 1'b0;
    bus.start = 1'b0; bus.kill = 1'b0; bus.op = OP_MUL; bus.a = '0; bus.b = '0;
    repeat (3) @(negedge gclk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_result", bus.result, 0);
    grst_n = 1'b1;
    @(negedge gclk);

    op_dir(OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul");
    op_dir(OP_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, "mulh");
    op_dir(OP_MULHU,  32'h8000_0000,  32'h8000_0000, 32'h4000_0000, "mulhu");
    op_dir(OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
    op_dir(OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, "div");
    op_dir(OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, "rem");
    op_dir(OP_DIVU,   32'd100,        32'd7,         32'd14,        "divu");
    op_dir(OP_REMU,   32'd100,        32'd7,         32'd2,         "remu");
    op_dir(OP_DIV,    32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFF, "div0");
    op_dir(OP_DIVU,   32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFF, "divu0");
    op_dir(OP_REM,    32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB, "rem0");
    op_dir(OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
    op_dir(OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         "rem_ovf");

    // start held through busy: exactly one done
    bus.start = 1'b1; bus.op = OP_DIVU; bus.a = 32'd1000; bus.b = 32'd9;
    begin
      exp_t e;
      e.res = 32'd111; e.due = cyc + 34; e.tag = "held";
      sb.push_back(e); last_res = e.res;
    end
    repeat (20) @(negedge gclk);
    bus.start = 1'b0;
    run_done(n);
    repeat (40) @(negedge gclk);

    // kill mid-CALC: no done, result unchanged, next op fine
    issue(OP_MUL, 32'd3, 32'd5, 1'b0);
    repeat (9) @(negedge gclk);
    bus.kill = 1'b1;
    @(negedge gclk);
    bus.kill = 1'b0;
    chk("kill_busy", bus.busy, 0);
    repeat (40) @(negedge gclk);
    chk("kill_result", bus.result, last_res);
    op_dir(OP_MUL, 32'd3, 32'd5, 32'd15, "post_kill");

    // back-to-back: start in the done cycle
    issue(OP_REMU, 32'd50, 32'd8, 1'b1);
    run_done(n);
    issue(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    run_done(n);
    chk("b2b_lat", n, 33);
    chk("b2b_res", bus.result, 32'hFFFF_FFFE);
    @(negedge gclk);

    // async reset mid-CALC
    issue(OP_DIV, 32'd77, 32'd3, 1'b0);
    repeat (5) @(negedge gclk);
    grst_n = 1'b0;
    #1;
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_done", bus.done, 0);
    chk("mrst_result", bus.result, 0);
    @(negedge gclk);
    grst_n = 1'b1;
    last_res = '0;
    @(negedge gclk);

    // random ops, mixed gaps and back-to-back
    for (int i = 0; i < 40; i++) begin
      issue(muldiv_op_e'($urandom_range(0, 7)), pick(), pick(), 1'b1);
      run_done(n);
      chk("rand_lat", n, 33);
      if ($urandom_range(0, 1) == 1) @(negedge gclk);
    end

    repeat (40) @(negedge gclk);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit; the multi-cycle counterpart to the single-cycle combinational ALU in the execute stage.
- Accepts an operation on a start strobe and reports busy for the duration. It returns a registered result with a one-cycle done pulse.
- The result feeds the same writeback mux as ALUout. The control unit stalls the PC and fetch while busy is high.

Parameters:
- WIDTH, 32: operand and result width in bits; must be even and at least 4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- kill  in  1  synchronous abort (pipeline flush).
- op  in  3  operation, equal to instruction funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  in  WIDTH  rs1 operand; sampled with start.
- b  in  WIDTH  rs2 operand; sampled with start.
- busy  out  1  an operation is in flight.
- done  out  1  one-cycle pulse; result is valid while done is high.
- result  out  WIDTH  registered result; holds its value until the next done.

Behaviour:
- Reset:
  - Asynchronous, active-low.
  - State goes to IDLE; busy=0, done=0, result=0; counter, operand and accumulator registers are cleared.
  - Reset mid-operation discards the operation; no done is produced.
- States: IDLE, CALC, FIN.
- IDLE:
  - If start=1 at an edge (edge 0): latch op, register the absolute values of a and b (signed ops only), latch the sign flags, and detect the special cases.
  - Load counter=WIDTH-1, then go to CALC.
  - Special cases detected at load: b==0; signed overflow (a==most-negative and b==all-ones).
- CALC, one step per edge:
  - Multiply: shift-add over a 2*WIDTH accumulator.
  - Divide: restoring step, remainder shifted left 1 then trial-subtract the divisor; quotient bit = not-borrow.
  - When counter==0, go to FIN; otherwise decrement the counter.
  - Edges 1..WIDTH perform the WIDTH iterations.
- FIN, at edge WIDTH+1:
  - Apply sign correction and the special-case overrides, write result, set done=1, go to IDLE.
  - Latency is fixed: done is high in the cycle after edge WIDTH+1 (33 for WIDTH=32), independent of operand values and special cases.
- busy is 1 in CALC and FIN, and 0 in IDLE. busy falls in the same cycle done rises.
- done is high for exactly one cycle. A start during the done cycle is accepted; back-to-back throughput is WIDTH+2 cycles per operation.
- start while busy is ignored: no queuing, operands are not resampled.
- kill=1 at an edge in CALC or FIN: go to IDLE, done stays 0, result keeps its previous value. kill has priority over start; kill in IDLE is a no-op.
- Result selection:
  - MUL: low WIDTH bits of the product.
  - MULH: high WIDTH bits, signed×signed.
  - MULHSU: high WIDTH bits, signed a × unsigned b.
  - MULHU: high WIDTH bits, unsigned×unsigned.
- Sign correction:
  - Product is negated iff the effective operand signs differ.
  - Quotient is negated iff sign(a)≠sign(b).
  - Remainder takes the sign of a.
- Override rules, applied at FIN:
  - b==0: DIV/DIVU give all-ones; REM/REMU give the original a.
  - Signed overflow: DIV gives most-negative; REM gives 0.
- All arithmetic is modulo 2^WIDTH; overflow in MUL is not flagged.

Decomposition:
- muldiv_pkg holds:
  - muldiv_op_e, a 3-bit enum whose values equal funct3;
  - state_e enum {IDLE, CALC, FIN};
  - localparam CNT_W = $clog2(WIDTH).
- No sub-module is required. The datapath (accumulator, shifter, subtractor) and the FSM live in one module.

Test Plan:
- MUL a=7, b=-3 → done exactly 33 cycles after the start edge; result=32'hFFFF_FFEB; busy high for 33 cycles.
- MULH a=32'h8000_0000, b=32'h8000_0000 → result=32'h4000_0000. MULHU on the same operands → 32'h4000_0000. MULHSU a=-1, b=32'hFFFF_FFFF → 32'hFFFF_FFFF.
- DIV a=-7, b=2 → result=-3 (32'hFFFF_FFFD). REM on the same operands → -1. DIVU a=100, b=7 → 14. REMU → 2.
- Divide by zero, a=-5, b=0:
  - DIV → 32'hFFFF_FFFF; DIVU → 32'hFFFF_FFFF; REM → 32'hFFFF_FFFB.
  - Latency is still 33 cycles.
- Signed overflow, a=32'h8000_0000, b=-1:
  - DIV → 32'h8000_0000; REM → 0.
- Control and boundary behaviour:
  - start held high while busy → only one done.
  - kill at cycle 10 → no done, result unchanged, next start completes normally.
  - rst_n low mid-CALC → busy=0, done=0, result=0 immediately.
  - start asserted during the done cycle → accepted; second done follows 33 cycles later.
